// File: rtl/stopwatch_display.sv
// -----------------------------------------------------------------------------
// stopwatch_display
//
// Takes the stopwatch counter's binary time fields, converts them to BCD with
// a sequential shift-add-3 (double dabble) engine, and drives an 8-digit
// multiplexed common-anode 7-segment display as H.MM.SS.mmm.
//
// The conversion runs continuously with a fixed 24-cycle period:
//   LOAD   (1 cycle)   snapshot inputs, saturate ms to 999, clear accumulators
//   SHIFT  (22 cycles) 10 ms bits, then 6 seconds bits, then 6 minutes bits
//   COMMIT (1 cycle)   copy all results to the digit register at once, pulse upd
// The digit register only changes in COMMIT, so the display never shows a
// half-converted value.
//
// Ports:
//   clk          in   system clock (same domain as the counter)
//   reset        in   synchronous, active-high
//   hours        in   [3:0] binary hours (10..15 displayed as 'E')
//   minutes      in   [5:0] binary minutes (60..63 shown as true values)
//   seconds      in   [5:0] binary seconds (60..63 shown as true values)
//   milliseconds in   [9:0] binary milliseconds (>999 saturates to 999)
//   blank        in   1 = all anodes off
//   an           out  [7:0] digit anodes, active-low one-hot, bit 0 = rightmost
//   seg          out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   dp           out  decimal point, active-low (lit on digits 7, 5, 3)
//   upd          out  one-cycle pulse in the cycle the digit register commits
//
// Parameter:
//   SCAN_DIV     clk cycles each digit stays lit (2 .. 2^20-1)
// -----------------------------------------------------------------------------
module stopwatch_display #(
   parameter int SCAN_DIV = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] hours,
   input  logic [5:0] minutes,
   input  logic [5:0] seconds,
   input  logic [9:0] milliseconds,
   input  logic       blank,
   output logic [7:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       upd
);

   localparam logic [19:0] SCAN_LAST = 20'(SCAN_DIV - 1);
   localparam logic [4:0]  MS_BITS   = 5'd10;  // bit counts 0..9 shift ms
   localparam logic [4:0]  SEC_END   = 5'd16;  // 10..15 shift seconds
   localparam logic [4:0]  LAST_BIT  = 5'd21;  // 16..21 shift minutes
   localparam logic [9:0]  MS_MAX    = 10'd999;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_next;
   logic   w_upd;

   // Conversion datapath
   logic [4:0]  r_bit_cnt;
   logic [9:0]  r_ms_sh;
   logic [5:0]  r_sec_sh;
   logic [5:0]  r_min_sh;
   logic [3:0]  r_hours_snap;
   logic [11:0] r_ms_bcd;
   logic [7:0]  r_sec_bcd;
   logic [7:0]  r_min_bcd;
   logic [11:0] w_ms_adj;
   logic [7:0]  w_sec_adj;
   logic [7:0]  w_min_adj;

   // Display side
   logic [7:0][3:0] r_digit;
   logic [19:0]     r_scan_cnt;
   logic [2:0]      r_idx;
   logic [7:0]      r_an;
   logic [6:0]      r_seg;
   logic            r_dp;

   // -------------------------------------------------------------------------
   // Add-3 correction applied to every BCD nibble before it is shifted.
   // -------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_ms_adj
         assign w_ms_adj[gi*4 +: 4] = (r_ms_bcd[gi*4 +: 4] >= 4'd5) ?
                                      r_ms_bcd[gi*4 +: 4] + 4'd3 :
                                      r_ms_bcd[gi*4 +: 4];
      end
      for (genvar gi = 0; gi < 2; gi++) begin : g_hms_adj
         assign w_sec_adj[gi*4 +: 4] = (r_sec_bcd[gi*4 +: 4] >= 4'd5) ?
                                       r_sec_bcd[gi*4 +: 4] + 4'd3 :
                                       r_sec_bcd[gi*4 +: 4];
         assign w_min_adj[gi*4 +: 4] = (r_min_bcd[gi*4 +: 4] >= 4'd5) ?
                                       r_min_bcd[gi*4 +: 4] + 4'd3 :
                                       r_min_bcd[gi*4 +: 4];
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Conversion FSM
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_LOAD;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_upd        = 1'b0;
      case (r_state)
         ST_LOAD: begin
            w_state_next = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (r_bit_cnt == LAST_BIT) begin
               w_state_next = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            w_upd        = 1'b1;
            w_state_next = ST_LOAD;
         end
         default: begin
            w_state_next = ST_LOAD;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Conversion datapath and digit register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bit_cnt    <= '0;
         r_ms_sh      <= '0;
         r_sec_sh     <= '0;
         r_min_sh     <= '0;
         r_hours_snap <= '0;
         r_ms_bcd     <= '0;
         r_sec_bcd    <= '0;
         r_min_bcd    <= '0;
         r_digit      <= '0;
      end else begin
         case (r_state)
            ST_LOAD: begin
               r_ms_sh      <= (milliseconds > MS_MAX) ? MS_MAX : milliseconds;
               r_sec_sh     <= seconds;
               r_min_sh     <= minutes;
               r_hours_snap <= hours;
               r_ms_bcd     <= '0;
               r_sec_bcd    <= '0;
               r_min_bcd    <= '0;
               r_bit_cnt    <= '0;
            end
            ST_SHIFT: begin
               r_bit_cnt <= r_bit_cnt + 5'd1;
               // Fields are processed back to back, MSB first, each into its
               // own accumulator so no cross-field carry is possible.
               if (r_bit_cnt < MS_BITS) begin
                  r_ms_bcd <= {w_ms_adj[10:0], r_ms_sh[9]};
                  r_ms_sh  <= {r_ms_sh[8:0], 1'b0};
               end else if (r_bit_cnt < SEC_END) begin
                  r_sec_bcd <= {w_sec_adj[6:0], r_sec_sh[5]};
                  r_sec_sh  <= {r_sec_sh[4:0], 1'b0};
               end else begin
                  r_min_bcd <= {w_min_adj[6:0], r_min_sh[5]};
                  r_min_sh  <= {r_min_sh[4:0], 1'b0};
               end
            end
            ST_COMMIT: begin
               r_digit[0] <= r_ms_bcd[3:0];
               r_digit[1] <= r_ms_bcd[7:4];
               r_digit[2] <= r_ms_bcd[11:8];
               r_digit[3] <= r_sec_bcd[3:0];
               r_digit[4] <= r_sec_bcd[7:4];
               r_digit[5] <= r_min_bcd[3:0];
               r_digit[6] <= r_min_bcd[7:4];
               r_digit[7] <= r_hours_snap;
            end
            default: begin
               r_bit_cnt <= '0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Scan timing: digit index advances once every SCAN_DIV cycles.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_scan_cnt <= '0;
         r_idx      <= '0;
      end else if (r_scan_cnt == SCAN_LAST) begin
         r_scan_cnt <= '0;
         r_idx      <= r_idx + 3'd1;
      end else begin
         r_scan_cnt <= r_scan_cnt + 20'd1;
      end
   end

   // Active-low glyphs; any value above 9 (only reachable from hours) is 'E'.
   function automatic logic [6:0] glyph(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'd0:    g = 7'b1000000;
         4'd1:    g = 7'b1111001;
         4'd2:    g = 7'b0100100;
         4'd3:    g = 7'b0110000;
         4'd4:    g = 7'b0011001;
         4'd5:    g = 7'b0010010;
         4'd6:    g = 7'b0000010;
         4'd7:    g = 7'b1111000;
         4'd8:    g = 7'b0000000;
         4'd9:    g = 7'b0010000;
         default: g = 7'b0000110;
      endcase
      return g;
   endfunction

   // -------------------------------------------------------------------------
   // Registered display drivers (one cycle behind index / digit register).
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_an  <= 8'hFE;
         r_seg <= 7'b1000000;
         r_dp  <= 1'b1;
      end else begin
         r_an  <= blank ? 8'hFF : ~(8'd1 << r_idx);
         r_seg <= glyph(r_digit[r_idx]);
         // Separator dots sit after hours, minutes and seconds.
         r_dp  <= !((r_idx == 3'd7) || (r_idx == 3'd5) || (r_idx == 3'd3));
      end
   end

   assign an  = r_an;
   assign seg = r_seg;
   assign dp  = r_dp;
   assign upd = w_upd;

endmodule
